// File: rtl/cf_math_pkg.sv
// Shared width arithmetic helpers.
// Pure constant functions, usable at elaboration time.
package CfMath;

  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/cf_mult_seq.sv
// Sequential shift-and-add unsigned multiplier.
// Fixed WIDTH-cycle latency with valid/ready on both sides.
module cf_mult_seq
  import CfMath::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] prod_o,
  output logic               busy_o
);

  localparam int PW = 2 * WIDTH;
  localparam int LW = log2(WIDTH);
  localparam int CW = (LW > 1) ? LW : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $fatal(1, "cf_mult_seq: WIDTH must be 1..32");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [PW-1:0]   mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   prod_q;
  logic            in_rdy_q;
  logic            out_vld_q;
  logic            busy_q;
  logic [PW-1:0]   acc_next;

  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  // prod_q is only loaded on entry to DONE and cleared on exit,
  // so the product output reads zero whenever valid is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      prod_q    <= '0;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else if (flush_i) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      prod_q    <= '0;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid_i) begin
            mcand    <= {{WIDTH{1'b0}}, a_i};
            mplier   <= b_i;
            acc      <= '0;
            cnt      <= '0;
            state    <= RUN;
            in_rdy_q <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            out_vld_q <= 1'b1;
            prod_q    <= acc_next;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state     <= IDLE;
            out_vld_q <= 1'b0;
            prod_q    <= '0;
            busy_q    <= 1'b0;
            in_rdy_q  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_vld_q <= 1'b0;
          prod_q    <= '0;
          busy_q    <= 1'b0;
          in_rdy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_o  = in_rdy_q;
  assign out_valid_o = out_vld_q;
  assign prod_o      = prod_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_cf_mult_seq.sv
// Scoreboard bench for cf_mult_seq (WIDTH=8 and WIDTH=1).
// Expected products come from plain a*b arithmetic.
module tb_cf_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] prod;
  logic        busy;

  logic        flush1;
  logic        in_valid1;
  logic        in_ready1;
  logic [0:0]  a1;
  logic [0:0]  b1;
  logic        out_valid1;
  logic        out_ready1;
  logic [1:0]  prod1;
  logic        busy1;

  cf_mult_seq #(.WIDTH(8)) u8 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .prod_o(prod), .busy_o(busy)
  );

  cf_mult_seq #(.WIDTH(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush1),
    .in_valid_i(in_valid1), .in_ready_o(in_ready1),
    .a_i(a1), .b_i(b1),
    .out_valid_o(out_valid1), .out_ready_i(out_ready1),
    .prod_o(prod1), .busy_o(busy1)
  );

  typedef struct {
    logic [15:0] p;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   rdy_force_en = 1'b1;
  bit   rdy_force = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = rdy_force_en ? rdy_force : ($urandom % 4 != 0);
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [15:0] pp = '0;
  int          rise = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        check("rst_rdy", in_ready, 1);
        check("rst_vld", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_prod", prod, 0);
        pv = 1'b0;
        pr = 1'b0;
      end else begin
        check("rdy_vs_busy", in_ready, !busy);
        if (!out_valid) check("prod_zero", prod, 0);
        if (pv && !pr) begin
          check("hold_valid", out_valid, 1);
          check("hold_prod", prod, pp);
        end
        if (out_valid && !pv) rise = cyc;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_out: got prod %0h want no output", prod);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("prod", prod, e.p);
            check("latency", rise - e.acc, 8);
          end
        end
        pv = out_valid;
        pr = out_ready;
        pp = prod;
      end
    end
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y);
    int n;
    n = 0;
    a = x;
    b = y;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready 0 want 1");
      in_valid = 1'b0;
      return;
    end
    tick();
    q.push_back(exp_t'{p: 16'(x) * 16'(y), acc: cyc});
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    flush1 = 1'b0;
    in_valid1 = 1'b0;
    a1 = '0;
    b1 = '0;
    out_ready1 = 1'b1;
    mon_en = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      a1 = 1'(i >> 1);
      b1 = 1'(i);
      in_valid1 = 1'b1;
      check("w1_rdy", in_ready1, 1);
      tick();
      in_valid1 = 1'b0;
      check("w1_run_vld", out_valid1, 0);
      tick();
      check("w1_vld", out_valid1, 1);
      check("w1_prod", prod1, 2'(a1 & b1));
      tick();
      check("w1_idle", in_ready1, 1);
    end

    send(8'd3, 8'd5);
    drain();
    tick();
    check("rdy_after_hs", in_ready, 1);
    send(8'd255, 8'd255);
    send(8'd0, 8'd200);
    drain();

    rdy_force = 1'b0;
    send(8'd7, 8'd9);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = 8'd1;
      b = 8'd1;
      check("stall_vld", out_valid, 1);
      check("stall_prod", prod, 16'd63);
      tick();
    end
    in_valid = 1'b0;
    rdy_force = 1'b1;
    drain();

    send(8'd10, 8'd10);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    q.delete();
    check("mid_rst_rdy", in_ready, 1);
    check("mid_rst_vld", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_prod", prod, 0);
    rst_n = 1'b1;
    repeat (12) tick();
    send(8'd2, 8'd2);
    drain();

    in_valid = 1'b1;
    flush = 1'b1;
    a = 8'd4;
    b = 8'd4;
    tick();
    in_valid = 1'b0;
    flush = 1'b0;
    check("flush_noacc", busy, 0);
    send(8'd6, 8'd7);
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    q.delete();
    check("flush_busy", busy, 0);
    check("flush_rdy", in_ready, 1);
    repeat (12) tick();
    send(8'd5, 8'd6);
    drain();

    rdy_force_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] x;
      logic [7:0] y;
      x = 8'($urandom);
      y = 8'($urandom);
      if (i % 7 == 0) x = 8'hff;
      if (i % 9 == 0) y = 8'h00;
      if (i % 11 == 0) y = 8'hff;
      send(x, y);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    rdy_force_en = 1'b1;
    repeat (3) tick();

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
